pe_conv_engine: RTL and testbench

Self-sequenced convolution processing element. It replaces the externally driven index/counter datapath with an internal FSM. The engine walks every KxK window of an IMG_SIZE x IMG_SIZE image at a configurable stride, across NUM_CH channels, and multiply-accumulates each window against per-channel filters. Each result is scaled and clipped, PACK results are packed per word, and the words are written into an internal result memory that downstream layers and the bench read back.

---
 rtl/pe_conv_engine.sv | 199 +++++++++++++++++++
 tb/tb_pe_conv_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_conv_engine.sv
// Self-sequenced convolution PE: walks every KxK window across all channels,
// scales/clips each sum, packs PACK results per word into a local result memory.
module pe_conv_engine #(
  parameter  int NUM_CH    = 1,
  parameter  int IMG_SIZE  = 16,
  parameter  int K         = 4,
  parameter  int STRIDE    = 1,
  parameter  int DATA_W    = 8,
  parameter  int ACC_W     = 20,
  parameter  int OUT_SHIFT = 4,
  parameter  int PACK      = 4,
  parameter  int MEM_DEPTH = 128,
  localparam int AW        = $clog2(IMG_SIZE * IMG_SIZE),
  localparam int MAW       = $clog2(MEM_DEPTH)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    start_i,
  input  logic                                    sat_en_i,
  input  logic [NUM_CH-1:0][K*K-1:0][DATA_W-1:0]  filters_i,
  output logic [AW-1:0]                           img_addr_o,
  output logic                                    img_rd_o,
  input  logic [NUM_CH-1:0][DATA_W-1:0]           img_data_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  input  logic [MAW-1:0]                          rd_addr_i,
  output logic [PACK*DATA_W-1:0]                  rd_data_o
);

  localparam int OUT_DIM = (IMG_SIZE - K) / STRIDE + 1;
  localparam int KW      = (K > 1) ? $clog2(K) : 1;
  localparam int TW      = (K * K > 1) ? $clog2(K * K) : 1;
  localparam int DW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int SW      = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW      = PACK * DATA_W;
  localparam logic [ACC_W-1:0] RES_MAX = ACC_W'((1 << DATA_W) - 1);

  if (ACC_W < 2 * DATA_W + $clog2(K * K * NUM_CH)) begin : g_acc_width_check
    $error("pe_conv_engine: ACC_W too narrow for the worst-case window sum");
  end
  if ((OUT_DIM * OUT_DIM + PACK - 1) / PACK > MEM_DEPTH) begin : g_mem_depth_check
    $error("pe_conv_engine: MEM_DEPTH too small for all packed results");
  end

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, STORE, DONE} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     kx_q, kx_d, ky_q, ky_d;
  logic [DW-1:0]     row_q, row_d, col_q, col_d;
  logic [TW-1:0]     prevTap_q, prevTap_d;
  logic              rdPend_q, rdPend_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PW-1:0]     pack_q, pack_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [MAW-1:0]    wrPtr_q, wrPtr_d;
  logic              sat_q, sat_d;
  logic [PW-1:0]     mem_q [MEM_DEPTH];

  logic              lastTap, lastWin, memWe;
  logic [ACC_W-1:0]  macSum, scaled;
  logic [DATA_W-1:0] result;
  logic [PW-1:0]     packNext;

  assign lastTap = (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1));
  assign lastWin = (row_q == DW'(OUT_DIM - 1)) && (col_q == DW'(OUT_DIM - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (lastTap) state_d = DRAIN;
      DRAIN:   state_d = STORE;
      STORE:   state_d = lastWin ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q == RUN) || (state_q == DRAIN) || (state_q == STORE);
    done_o   = (state_q == DONE);
    img_rd_o = (state_q == RUN);
  end

  // Data for the tap issued last cycle arrives now; prevTap_q selects its coefficient.
  always_comb begin
    macSum = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      macSum = macSum + ACC_W'(img_data_i[ch]) * ACC_W'(filters_i[ch][prevTap_q]);
    end
  end

  always_comb begin
    img_addr_o = AW'((int'(row_q) * STRIDE + int'(ky_q)) * IMG_SIZE
                     + int'(col_q) * STRIDE + int'(kx_q));
    scaled     = acc_q >> OUT_SHIFT;
    result     = (sat_q && (scaled > RES_MAX)) ? '1 : scaled[DATA_W-1:0];
    packNext   = pack_q | (PW'(result) << (int'(slot_q) * DATA_W));
    memWe      = (state_q == STORE) && ((slot_q == SW'(PACK - 1)) || lastWin);
  end

  always_comb begin
    kx_d      = kx_q;
    ky_d      = ky_q;
    row_d     = row_q;
    col_d     = col_q;
    slot_d    = slot_q;
    wrPtr_d   = wrPtr_q;
    pack_d    = pack_q;
    sat_d     = sat_q;
    rdPend_d  = img_rd_o;
    prevTap_d = TW'(int'(ky_q) * K + int'(kx_q));
    acc_d     = rdPend_q ? acc_q + macSum : acc_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sat_d   = sat_en_i;
          kx_d    = '0;
          ky_d    = '0;
          row_d   = '0;
          col_d   = '0;
          slot_d  = '0;
          wrPtr_d = '0;
          pack_d  = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (kx_q == KW'(K - 1)) begin
          kx_d = '0;
          ky_d = lastTap ? '0 : ky_q + 1'b1;
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
      STORE: begin
        acc_d = '0;
        if (memWe) begin
          pack_d  = '0;
          slot_d  = '0;
          wrPtr_d = wrPtr_q + 1'b1;
        end else begin
          pack_d  = packNext;
          slot_d  = slot_q + 1'b1;
        end
        if (!lastWin) begin
          if (col_q == DW'(OUT_DIM - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kx_q      <= '0;
      ky_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      prevTap_q <= '0;
      rdPend_q  <= 1'b0;
      acc_q     <= '0;
      pack_q    <= '0;
      slot_q    <= '0;
      wrPtr_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      row_q     <= row_d;
      col_q     <= col_d;
      prevTap_q <= prevTap_d;
      rdPend_q  <= rdPend_d;
      acc_q     <= acc_d;
      pack_q    <= pack_d;
      slot_q    <= slot_d;
      wrPtr_q   <= wrPtr_d;
      sat_q     <= sat_d;
    end
  end

  // Result memory is deliberately not reset so earlier words survive an aborted run.
  always_ff @(posedge clk_i) begin
    if (!rst_i && memWe) mem_q[wrPtr_q] <= packNext;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: tb/tb_pe_conv_engine.sv
// Bench for pe_conv_engine: a behavioural window model fills a scoreboard queue,
// result memory is read back after done; plus reset-abort and ignored-start sequences.
module tb_pe_conv_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic                  start, satEn;
  logic [0:0][15:0][7:0] filt;
  logic [7:0]            imgAddr;
  logic                  imgRd;
  logic [0:0][7:0]       imgData;
  logic                  busy, done;
  logic [6:0]            rdAddr;
  logic [31:0]           rdData;

  logic                  start2, satEn2;
  logic [1:0][15:0][7:0] filt2;
  logic [7:0]            imgAddr2;
  logic                  imgRd2;
  logic [1:0][7:0]       imgData2;
  logic                  busy2, done2;
  logic [6:0]            rdAddr2;
  logic [31:0]           rdData2;

  pe_conv_engine dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sat_en_i(satEn), .filters_i(filt),
    .img_addr_o(imgAddr), .img_rd_o(imgRd), .img_data_i(imgData),
    .busy_o(busy), .done_o(done), .rd_addr_i(rdAddr), .rd_data_o(rdData)
  );

  pe_conv_engine #(.NUM_CH(2), .STRIDE(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .sat_en_i(satEn2), .filters_i(filt2),
    .img_addr_o(imgAddr2), .img_rd_o(imgRd2), .img_data_i(imgData2),
    .busy_o(busy2), .done_o(done2), .rd_addr_i(rdAddr2), .rd_data_o(rdData2)
  );

  int pix [2][256];
  int coef[2][16];

  // Image memory model: data for a read appears one cycle after the strobe.
  always @(posedge clk) begin
    if (imgRd) imgData[0] <= 8'(pix[0][imgAddr]);
    if (imgRd2) for (int ch = 0; ch < 2; ch++) imgData2[ch] <= 8'(pix[ch][imgAddr2]);
  end

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastWords[128];

  typedef struct {
    int          imgMode;
    int          filtMode;
    bit          sat;
    logic [31:0] w0;
    logic [31:0] w3;
    logic [31:0] w42;
  } vec_t;
  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic loadPattern(input int imgMode, input int filtMode);
    for (int ch = 0; ch < 2; ch++) begin
      for (int a = 0; a < 256; a++)
        pix[ch][a] = (imgMode == 0) ? 1 : (imgMode == 1) ? (a & 255) : 255;
      for (int t = 0; t < 16; t++) begin
        coef[ch][t] = (filtMode == 0) ? 1 : (filtMode == 1) ? ((t == 0) ? 16 : 0) : 255;
        filt2[ch][t] = 8'(coef[ch][t]);
      end
    end
    for (int t = 0; t < 16; t++) filt[0][t] = 8'(coef[0][t]);
  endtask

  // Reference: full-precision window sums, shift, clip/truncate, pack LSB-first.
  task automatic modelRun(input int nch, input int stride, input bit sat, output int nWords);
    int          od, slot;
    longint      acc, s;
    logic [7:0]  res;
    logic [31:0] word;
    od = (16 - 4) / stride + 1;
    nWords = 0;
    slot = 0;
    word = '0;
    for (int r = 0; r < od; r++) begin
      for (int c = 0; c < od; c++) begin
        acc = 0;
        for (int ky = 0; ky < 4; ky++)
          for (int kx = 0; kx < 4; kx++)
            for (int ch = 0; ch < nch; ch++)
              acc += longint'(pix[ch][(r * stride + ky) * 16 + c * stride + kx]) * coef[ch][ky * 4 + kx];
        s = acc >> 4;
        res = (sat && s > 255) ? 8'hFF : 8'(s);
        word[slot * 8 +: 8] = res;
        slot++;
        if (slot == 4 || (r == od - 1 && c == od - 1)) begin
          lastWords[nWords] = word;
          expQ.push_back(word);
          nWords++;
          word = '0;
          slot = 0;
        end
      end
    end
  endtask

  task automatic readWord(input bit sel, input int addr, output logic [31:0] data);
    @(negedge clk);
    if (sel) rdAddr2 = 7'(addr);
    else     rdAddr  = 7'(addr);
    #1;
    data = sel ? rdData2 : rdData;
  endtask

  task automatic readBack(input bit sel, input int nWords, input string tag);
    logic [31:0] act;
    for (int i = 0; i < nWords; i++) begin
      readWord(sel, i, act);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s word%0d: got 0x%08h, scoreboard empty", tag, i, act);
      end else begin
        checkOutput($sformatf("%s word%0d", tag, i), act, expQ.pop_front());
      end
    end
  endtask

  // Starts a run, then follows it edge by edge until done (bounded), checking the
  // read-address sequence, busy and done latency; optionally pulses start mid-run.
  task automatic applyStimulus(input bit sel, input bit sat, input int expEdges,
                               input int stride, input int pulseAt, input string tag);
    int   edges, reads, addrErr, busyErr, extraDone, od, limit, w, t, expA;
    bit   d, r, b;
    logic [7:0] a;
    od = (16 - 4) / stride + 1;
    limit = expEdges + 200;
    edges = 0; reads = 0; addrErr = 0; busyErr = 0; extraDone = 0;
    @(negedge clk);
    if (sel) begin start2 = 1'b1; satEn2 = sat; end
    else     begin start  = 1'b1; satEn  = sat; end
    @(posedge clk);
    #1;
    start = 1'b0;
    start2 = 1'b0;
    while (1) begin
      d = sel ? done2 : done;
      r = sel ? imgRd2 : imgRd;
      a = sel ? imgAddr2 : imgAddr;
      b = sel ? busy2 : busy;
      if (d || edges >= limit) break;
      if (!b) busyErr++;
      if (r) begin
        w = reads / 16;
        t = reads % 16;
        expA = ((w / od) * stride + t / 4) * 16 + (w % od) * stride + t % 4;
        if (int'(a) != expA) addrErr++;
        reads++;
      end
      start = (!sel && edges == pulseAt);
      @(posedge clk);
      edges++;
      #1;
    end
    start = 1'b0;
    checkOutput({tag, " done seen"}, 32'(d), 32'd1);
    checkOutput({tag, " done latency"}, edges, expEdges);
    checkOutput({tag, " read count"}, reads, od * od * 16);
    checkOutput({tag, " addr errors"}, addrErr, 0);
    checkOutput({tag, " busy drops"}, busyErr, 0);
    checkOutput({tag, " busy at done"}, 32'(sel ? busy2 : busy), 32'd0);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (sel ? done2 : done) extraDone++;
    end
    checkOutput({tag, " extra done"}, extraDone, 0);
    checkOutput({tag, " busy after"}, 32'(sel ? busy2 : busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          nw;
    logic [31:0] act, oldW1;

    vecs[0] = '{0, 0, 1'b1, 32'h01010101, 32'h01010101, 32'h00000001};
    vecs[1] = '{1, 1, 1'b1, 32'h03020100, 32'h1211100C, 32'h000000CC};
    vecs[2] = '{2, 2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000000FF};
    vecs[3] = '{2, 2, 1'b0, 32'h01010101, 32'h01010101, 32'h00000001};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; satEn = 1'b0; satEn2 = 1'b0;
    rdAddr = '0; rdAddr2 = '0; filt = '0; filt2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset img_rd", 32'(imgRd), 32'd0);
    checkOutput("reset busy2", 32'(busy2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);

    for (int v = 0; v < 4; v++) begin
      loadPattern(vecs[v].imgMode, vecs[v].filtMode);
      modelRun(1, 1, vecs[v].sat, nw);
      applyStimulus(1'b0, vecs[v].sat, 3042, 1, -1, $sformatf("vec%0d", v));
      readWord(1'b0, 0, act);
      checkOutput($sformatf("vec%0d mem0", v), act, vecs[v].w0);
      readWord(1'b0, 3, act);
      checkOutput($sformatf("vec%0d mem3", v), act, vecs[v].w3);
      readWord(1'b0, 42, act);
      checkOutput($sformatf("vec%0d mem42", v), act, vecs[v].w42);
      readBack(1'b0, nw, $sformatf("vec%0d", v));
    end

    // Abort a run during window 5, then rerun to completion.
    oldW1 = lastWords[1];
    loadPattern(1, 1);
    @(negedge clk);
    start = 1'b1; satEn = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (95) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort img_rd", 32'(imgRd), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort stays idle", 32'(busy), 32'd0);
    readWord(1'b0, 0, act);
    checkOutput("abort mem0 written", act, 32'h03020100);
    readWord(1'b0, 1, act);
    checkOutput("abort mem1 kept", act, oldW1);
    modelRun(1, 1, 1'b1, nw);
    applyStimulus(1'b0, 1'b1, 3042, 1, -1, "rerun");
    readBack(1'b0, nw, "rerun");

    // start pulsed mid-run must be ignored.
    loadPattern(0, 0);
    modelRun(1, 1, 1'b1, nw);
    applyStimulus(1'b0, 1'b1, 3042, 1, 500, "midstart");
    readBack(1'b0, nw, "midstart");

    // Two channels, stride 4.
    loadPattern(0, 0);
    modelRun(2, 4, 1'b1, nw);
    applyStimulus(1'b1, 1'b1, 288, 4, -1, "ch2s4");
    readWord(1'b1, 0, act);
    checkOutput("ch2s4 mem0", act, 32'h02020202);
    readBack(1'b1, nw, "ch2s4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
